// File: rtl/proc_mem_pkg.sv
// Shared constants, region type and address decoder for the processor memory responder.
package proc_mem_pkg;

  localparam logic [15:0] MBOX_DATA_ADDR = 16'hFFF0;
  localparam logic [15:0] MBOX_STAT_ADDR = 16'hFFF1;
  localparam logic [15:0] VEC_NMI_ADDR   = 16'hFFFA;
  localparam logic [15:0] VEC_RST_ADDR   = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_ADDR   = 16'hFFFE;

  localparam int unsigned ST_FULL  = 7;
  localparam int unsigned ST_EMPTY = 6;
  localparam int unsigned ST_OVF   = 5;

  typedef enum logic [2:0] {
    RGN_VEC   = 3'd0,
    RGN_MDATA = 3'd1,
    RGN_MSTAT = 3'd2,
    RGN_RAM   = 3'd3,
    RGN_OPEN  = 3'd4
  } region_e;

  // Priority decode: vectors, mailbox registers, RAM, then open bus.
  function automatic region_e decode_region(input logic [15:0] addr, input int unsigned ram_aw);
    if (addr >= VEC_NMI_ADDR)           return RGN_VEC;
    else if (addr == MBOX_DATA_ADDR)    return RGN_MDATA;
    else if (addr == MBOX_STAT_ADDR)    return RGN_MSTAT;
    else if (32'(addr) < (32'd1 << ram_aw)) return RGN_RAM;
    else                                return RGN_OPEN;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head; storage is not reset.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A full FIFO still accepts a push when a pop frees the head slot that same cycle.
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Entry storage, written at the tail.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/proc_mem_responder.sv
// Processor memory-port responder: RAM, vector ROM and a mailbox FIFO with 1-cycle registered reads.
module proc_mem_responder
  import proc_mem_pkg::*;
#(
  parameter int unsigned RAM_AW     = 11,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] RST_VEC    = 16'h0200,
  parameter logic [15:0] NMI_VEC    = 16'h0300,
  parameter logic [15:0] IRQ_VEC    = 16'h0400,
  parameter logic [7:0]  OPEN_BUS   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        wr_enable,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        rdy,
  output logic        mbox_valid,
  output logic [7:0]  mbox_data,
  input  logic        mbox_ready
);

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  region_e        w_rgn;
  logic           w_wr_ram;
  logic           w_push;
  logic           w_pop;
  logic           w_stat_wr;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  logic [7:0]     w_head;
  logic [15:0]    w_vec_word;
  logic [7:0]     w_rd_next;
  logic [7:0]     r_ram [RAM_WORDS];
  logic           r_ovf;

  assign w_rgn     = decode_region(address, RAM_AW);
  assign w_wr_ram  = wr_enable & ~reset & (w_rgn == RGN_RAM);
  assign w_push    = wr_enable & ~reset & (w_rgn == RGN_MDATA);
  assign w_stat_wr = wr_enable & (w_rgn == RGN_MSTAT);
  assign w_pop     = ~w_empty & mbox_ready;

  assign mbox_valid = ~w_empty;
  assign mbox_data  = w_empty ? 8'h00 : w_head;
  assign rdy        = ~w_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_mbox (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (wr_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // RAM array; contents survive reset, writes in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (w_wr_ram) r_ram[address[RAM_AW-1:0]] <= wr_data;
  end

  // Select the vector word from address bits [2:1]; 0xFFF8/9 never reaches here.
  always_comb begin
    w_vec_word = IRQ_VEC;
    case (address[2:1])
      2'b01:   w_vec_word = NMI_VEC;
      2'b10:   w_vec_word = RST_VEC;
      default: w_vec_word = IRQ_VEC;
    endcase
  end

  // Read mux from pre-write state, giving read-first behaviour on write cycles.
  always_comb begin
    w_rd_next = OPEN_BUS;
    case (w_rgn)
      RGN_VEC:   w_rd_next = address[0] ? w_vec_word[15:8] : w_vec_word[7:0];
      RGN_MDATA: w_rd_next = 8'(w_count);
      RGN_MSTAT: begin
        w_rd_next           = 8'h00;
        w_rd_next[ST_FULL]  = w_full;
        w_rd_next[ST_EMPTY] = w_empty;
        w_rd_next[ST_OVF]   = r_ovf;
      end
      RGN_RAM:   w_rd_next = r_ram[address[RAM_AW-1:0]];
      default:   w_rd_next = OPEN_BUS;
    endcase
  end

  // Registered read data, one cycle after the address.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= 8'h00;
    else       rd_data <= w_rd_next;
  end

  // Sticky overflow: a dropped push sets it and beats a same-cycle status-write clear.
  always_ff @(posedge clk) begin
    if (reset)                              r_ovf <= 1'b0;
    else if (w_push && w_full && !w_pop)    r_ovf <= 1'b1;
    else if (w_stat_wr)                     r_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Scoreboard bench for proc_mem_responder: directed scenarios followed by randomized bus traffic.
module tb_proc_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = 16'h0000;
  logic        wr_enable = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic [7:0]  rd_data;
  logic        rdy;
  logic        mbox_valid;
  logic [7:0]  mbox_data;
  logic        mbox_ready = 1'b0;

  always #5 clk = ~clk;

  proc_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .wr_enable  (wr_enable),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .rdy        (rdy),
    .mbox_valid (mbox_valid),
    .mbox_data  (mbox_data),
    .mbox_ready (mbox_ready)
  );

  typedef struct {
    logic [7:0] rd;
    bit         chk_rd;
    logic       vld;
    logic       rdy;
    string      name;
  } exp_t;

  exp_t       rq[$];
  logic [7:0] mexp[$];
  logic [7:0] mq[$];
  bit         ovf;
  logic [7:0] mram [2048];
  bit         mram_v [2048];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, want);
    end
  endtask

  // Reference read value from the memory map, using current (pre-edge) model state.
  function automatic logic [7:0] model_read(input logic [15:0] a);
    logic [15:0] vec;
    if (a >= 16'hFFFA) begin
      vec = (a < 16'hFFFC) ? 16'h0300 : (a < 16'hFFFE) ? 16'h0200 : 16'h0400;
      return a[0] ? vec[15:8] : vec[7:0];
    end
    if (a == 16'hFFF0) return 8'(mq.size());
    if (a == 16'hFFF1) return {(mq.size() == 8), (mq.size() == 0), ovf, 5'b00000};
    if (a < 16'h0800)  return mram[a[10:0]];
    return 8'hFF;
  endfunction

  // One bus cycle: drive inputs, predict the post-edge outputs and advance the model.
  task automatic cycle(input logic rst, input logic [15:0] a, input logic we,
                       input logic [7:0] d, input logic rin, input string nm);
    exp_t e;
    bit   pop;
    @(negedge clk);
    #1;
    reset = rst; address = a; wr_enable = we; wr_data = d; mbox_ready = rin;
    e.name = nm;
    if (rst) begin
      e.rd = 8'h00; e.chk_rd = 1'b1;
      mq.delete(); mexp.delete(); ovf = 1'b0;
    end else begin
      e.rd = model_read(a);
      e.chk_rd = !(a < 16'h0800 && !mram_v[a[10:0]]);
      pop = (mq.size() > 0) && rin;
      if (we && a == 16'hFFF1) ovf = 1'b0;
      if (pop) void'(mq.pop_front());
      if (we && a == 16'hFFF0) begin
        if (mq.size() < 8) begin
          mq.push_back(d);
          mexp.push_back(d);
        end else begin
          ovf = 1'b1;
        end
      end
      if (we && a < 16'h0800) begin
        mram[a[10:0]] = d;
        mram_v[a[10:0]] = 1'b1;
      end
    end
    e.vld = (mq.size() > 0);
    e.rdy = (mq.size() < 8);
    rq.push_back(e);
  endtask

  // Output monitor: read data and FIFO flags after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rq.size() > 0) begin
        e = rq.pop_front();
        if (e.chk_rd) chk({e.name, " rd_data"}, rd_data, e.rd);
        chk({e.name, " mbox_valid"}, 8'(mbox_valid), 8'(e.vld));
        chk({e.name, " rdy"}, 8'(rdy), 8'(e.rdy));
      end
    end
  end

  // Mailbox consumer monitor: compare each accepted head byte in order.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mbox_valid && mbox_ready) begin
        if (mexp.size() == 0) begin
          total++; bad++;
          $display("FAIL mbox_unexpected: got %02h want none", mbox_data);
        end else begin
          chk("mbox_data", mbox_data, mexp.pop_front());
        end
      end
    end
  end

  initial begin
    logic [15:0] a;
    logic        rbias;
    for (int i = 0; i < 2048; i++) mram_v[i] = 1'b0;
    ovf = 1'b0;

    cycle(1, 16'h0000, 0, 8'h00, 0, "rst0");
    cycle(1, 16'h0000, 0, 8'h00, 0, "rst1");

    cycle(0, 16'h0010, 1, 8'h5A, 0, "wr_0010");
    cycle(0, 16'h0010, 0, 8'h00, 0, "rd_0010");
    cycle(0, 16'h0010, 1, 8'h6B, 0, "rdfirst_0010");
    cycle(0, 16'h0010, 1, 8'h5A, 0, "restore_0010");
    cycle(0, 16'hFFFC, 0, 8'h00, 0, "rd_fffc");
    cycle(0, 16'hFFFD, 0, 8'h00, 0, "rd_fffd");
    cycle(0, 16'hFFFC, 1, 8'h55, 0, "wr_fffc");
    cycle(0, 16'hFFFC, 0, 8'h00, 0, "rd_fffc_again");
    cycle(0, 16'hFFFA, 0, 8'h00, 0, "rd_fffa");
    cycle(0, 16'hFFFF, 0, 8'h00, 0, "rd_ffff");

    for (int i = 1; i <= 9; i++) cycle(0, 16'hFFF0, 1, 8'(i), 0, $sformatf("push_%0d", i));
    cycle(0, 16'hFFF1, 0, 8'h00, 0, "stat_full_ovf");
    cycle(0, 16'hFFF0, 0, 8'h00, 0, "count_full");
    @(posedge clk);
    #2;
    chk("head_first", mbox_data, mq[0]);

    cycle(0, 16'hFFF0, 1, 8'h77, 1, "push_pop_full");
    for (int i = 0; i < 10; i++) cycle(0, 16'h0010, 0, 8'h00, 1, "drain");
    cycle(0, 16'hFFF1, 0, 8'h00, 0, "stat_empty_ovf");
    cycle(0, 16'hFFF1, 1, 8'h00, 0, "stat_clear");
    cycle(0, 16'hFFF1, 0, 8'h00, 0, "stat_cleared");

    cycle(0, 16'h0000, 1, 8'h33, 0, "wr_0000");
    cycle(0, 16'h9000, 0, 8'h00, 0, "rd_9000");
    cycle(0, 16'h9000, 1, 8'hCC, 0, "wr_9000");
    cycle(0, 16'h0000, 0, 8'h00, 0, "rd_alias_0000");
    cycle(0, 16'hFFF5, 0, 8'h00, 0, "rd_fff5");

    for (int i = 0; i < 3; i++) cycle(0, 16'hFFF0, 1, 8'(8'hA0 + i), 0, "push3");
    cycle(1, 16'h0010, 1, 8'hEE, 0, "rst_mid");
    cycle(0, 16'h0010, 0, 8'h00, 0, "rd_after_rst");
    cycle(0, 16'hFFF1, 0, 8'h00, 0, "stat_after_rst");

    rbias = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) rbias = ~rbias;
      case ($urandom_range(0, 6))
        0, 1:    a = 16'hFFF0;
        2:       a = 16'hFFF1;
        3:       a = 16'hFFFA + 16'($urandom_range(0, 5));
        4:       a = 16'($urandom_range(0, 31));
        5:       a = 16'h0800 + 16'($urandom_range(0, 16'hF7EF));
        default: a = 16'hFFF2 + 16'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 149) == 0)
        cycle(1, a, 1'($urandom_range(0, 1)), 8'($urandom), 0, "rnd_rst");
      else
        cycle(0, a, 1'($urandom_range(0, 1)), 8'($urandom),
              rbias ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0), "rnd");
    end

    for (int i = 0; i < 12; i++) cycle(0, 16'h0000, 0, 8'h00, 1, "final_drain");
    cycle(0, 16'hFFF0, 0, 8'h00, 0, "final_count");
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    chk("mbox_all_drained", 8'(mexp.size()), 8'd0);
    chk("scoreboard_empty", 8'(rq.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
